// File: rtl/sdio_xfer_seq.sv
// SDIO transfer sequencer: issues one command, then walks the DAT path through N blocks
// with inter-block gaps, block-gap stop/continue/abort and completion interrupt pulses.
module sdio_xfer_seq #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             sd_clk,
  input  logic             rstn,
  input  logic             sw_rst,
  input  logic             cmd_start,
  input  logic             dat_present,
  input  logic             dat_trans_dir,
  input  logic [CNT_W-1:0] block_count,
  input  logic             blk_gap_stop,
  input  logic             continue_req,
  input  logic             abort_req,
  input  logic             cmd_done,
  input  logic             cmd_err,
  input  logic             dat_blk_done,
  input  logic             dat_blk_err,
  output logic             cmd_issue,
  output logic             dat_blk_start,
  output logic             sd_clk_pause,
  output logic             cmd_complete_irq,
  output logic             dat_complete_irq,
  output logic             blk_gap_irq,
  output logic             xfer_err,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_left,
  output logic [2:0]       seq_state
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DAT  = 3'd2,
    S_GAP  = 3'd3,
    S_STOP = 3'd4
  } state_t;

  state_t           state, next_state;
  logic             dir_q, dat_present_q;
  logic [GW-1:0]    gap_cnt, gap_cnt_d;
  logic [CNT_W-1:0] blocks_left_d;
  logic             dir_d, dat_present_d;
  logic             cmd_issue_d, dat_blk_start_d, sd_clk_pause_d;
  logic             cmd_complete_d, dat_complete_d, blk_gap_d;
  logic             xfer_err_d, busy_d;

  // State and every registered output; sw_rst behaves exactly like rstn but synchronously.
  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_IDLE;
      dir_q            <= 1'b0;
      dat_present_q    <= 1'b0;
      gap_cnt          <= '0;
      blocks_left      <= '0;
      cmd_issue        <= 1'b0;
      dat_blk_start    <= 1'b0;
      sd_clk_pause     <= 1'b0;
      cmd_complete_irq <= 1'b0;
      dat_complete_irq <= 1'b0;
      blk_gap_irq      <= 1'b0;
      xfer_err         <= 1'b0;
      busy             <= 1'b0;
    end else if (sw_rst) begin
      state            <= S_IDLE;
      dir_q            <= 1'b0;
      dat_present_q    <= 1'b0;
      gap_cnt          <= '0;
      blocks_left      <= '0;
      cmd_issue        <= 1'b0;
      dat_blk_start    <= 1'b0;
      sd_clk_pause     <= 1'b0;
      cmd_complete_irq <= 1'b0;
      dat_complete_irq <= 1'b0;
      blk_gap_irq      <= 1'b0;
      xfer_err         <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= next_state;
      dir_q            <= dir_d;
      dat_present_q    <= dat_present_d;
      gap_cnt          <= gap_cnt_d;
      blocks_left      <= blocks_left_d;
      cmd_issue        <= cmd_issue_d;
      dat_blk_start    <= dat_blk_start_d;
      sd_clk_pause     <= sd_clk_pause_d;
      cmd_complete_irq <= cmd_complete_d;
      dat_complete_irq <= dat_complete_d;
      blk_gap_irq      <= blk_gap_d;
      xfer_err         <= xfer_err_d;
      busy             <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (cmd_start) next_state = S_CMD;
      S_CMD: begin
        if (cmd_err)
          next_state = S_IDLE;
        else if (cmd_done)
          next_state = (dat_present_q && blocks_left != '0) ? S_DAT : S_IDLE;
      end
      S_DAT: begin
        if (dat_blk_err)
          next_state = S_IDLE;
        else if (dat_blk_done) begin
          if (blocks_left <= CNT_W'(1)) next_state = S_IDLE;
          else if (blk_gap_stop)        next_state = S_STOP;
          else                          next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (blk_gap_stop)        next_state = S_STOP;
        else if (gap_cnt == '0)  next_state = S_DAT;
      end
      S_STOP: begin
        if (abort_req)                         next_state = S_IDLE;
        else if (continue_req && !blk_gap_stop) next_state = S_GAP;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; pulses are derived from state transitions.
  always_comb begin
    dir_d           = dir_q;
    dat_present_d   = dat_present_q;
    blocks_left_d   = blocks_left;
    xfer_err_d      = xfer_err;
    gap_cnt_d       = gap_cnt;
    cmd_issue_d     = (state == S_IDLE) && cmd_start;
    cmd_complete_d  = (state == S_CMD) && (cmd_done || cmd_err);
    dat_complete_d  = ((state == S_DAT) &&
                       (dat_blk_err || (dat_blk_done && blocks_left <= CNT_W'(1)))) ||
                      ((state == S_STOP) && abort_req);
    dat_blk_start_d = (next_state == S_DAT) && (state != S_DAT);
    blk_gap_d       = (next_state == S_STOP) && (state != S_STOP);
    sd_clk_pause_d  = (next_state == S_STOP) && dir_q;
    busy_d          = (next_state != S_IDLE);

    if (state == S_IDLE && cmd_start) begin
      dir_d         = dat_trans_dir;
      dat_present_d = dat_present;
      blocks_left_d = block_count;
      xfer_err_d    = 1'b0;
    end
    if (state == S_CMD && cmd_err) xfer_err_d = 1'b1;
    if (state == S_DAT && dat_blk_err) xfer_err_d = 1'b1;
    if (state == S_DAT && dat_blk_done && !dat_blk_err && blocks_left != '0)
      blocks_left_d = blocks_left - CNT_W'(1);

    if (next_state == S_GAP && state != S_GAP)
      gap_cnt_d = GW'(GAP_CYCLES - 1);
    else if (state == S_GAP && gap_cnt != '0)
      gap_cnt_d = gap_cnt - GW'(1);
  end

  assign seq_state = state;

endmodule

// File: tb/tb_sdio_xfer_seq.sv
// Directed self-checking bench for sdio_xfer_seq (GAP_CYCLES=2, CNT_W=16).
module tb_sdio_xfer_seq;
  logic        sd_clk, rstn, sw_rst;
  logic        cmd_start, dat_present, dat_trans_dir;
  logic [15:0] block_count;
  logic        blk_gap_stop, continue_req, abort_req;
  logic        cmd_done, cmd_err, dat_blk_done, dat_blk_err;
  logic        cmd_issue, dat_blk_start, sd_clk_pause;
  logic        cmd_complete_irq, dat_complete_irq, blk_gap_irq;
  logic        xfer_err, busy;
  logic [15:0] blocks_left;
  logic [2:0]  seq_state;
  logic [26:0] all_out;
  int          total, bad;

  sdio_xfer_seq #(.GAP_CYCLES(2), .CNT_W(16)) dut (
    .sd_clk(sd_clk), .rstn(rstn), .sw_rst(sw_rst),
    .cmd_start(cmd_start), .dat_present(dat_present), .dat_trans_dir(dat_trans_dir),
    .block_count(block_count), .blk_gap_stop(blk_gap_stop),
    .continue_req(continue_req), .abort_req(abort_req),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .dat_blk_done(dat_blk_done), .dat_blk_err(dat_blk_err),
    .cmd_issue(cmd_issue), .dat_blk_start(dat_blk_start), .sd_clk_pause(sd_clk_pause),
    .cmd_complete_irq(cmd_complete_irq), .dat_complete_irq(dat_complete_irq),
    .blk_gap_irq(blk_gap_irq), .xfer_err(xfer_err), .busy(busy),
    .blocks_left(blocks_left), .seq_state(seq_state)
  );

  assign all_out = {cmd_issue, dat_blk_start, sd_clk_pause, cmd_complete_irq,
                    dat_complete_irq, blk_gap_irq, xfer_err, busy, blocks_left, seq_state};

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic start_cmd(input logic dp, input logic dir, input logic [15:0] cnt);
    dat_present = dp; dat_trans_dir = dir; block_count = cnt; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    total++; if (all_out !== 27'd0) begin bad++; $display("[TB] FAIL reset_outputs: got %h want 0", all_out); end
    rstn = 1'b1;
    tick();
    total++; if (all_out !== 27'd0) begin bad++; $display("[TB] FAIL reset_release: got %h want 0", all_out); end
  endtask

  task automatic test_cmd_only();
    int starts = 0, issues = 0;
    start_cmd(1'b0, 1'b0, 16'd5);
    total++; if (cmd_issue !== 1'b1) begin bad++; $display("[TB] FAIL t1_issue: got %b want 1", cmd_issue); end
    total++; if (seq_state !== 3'd1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL t1_cmd_state: got %0d/%b want 1/1", seq_state, busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      issues += int'(cmd_issue); starts += int'(dat_blk_start);
    end
    total++; if (issues !== 0) begin bad++; $display("[TB] FAIL t1_issue_width: got %0d extra want 0", issues); end
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (cmd_complete_irq !== 1'b1) begin bad++; $display("[TB] FAIL t1_cc_irq: got %b want 1", cmd_complete_irq); end
    total++; if (busy !== 1'b0 || seq_state !== 3'd0) begin bad++; $display("[TB] FAIL t1_idle: got %b/%0d want 0/0", busy, seq_state); end
    starts += int'(dat_blk_start);
    tick();
    starts += int'(dat_blk_start);
    total++; if (cmd_complete_irq !== 1'b0) begin bad++; $display("[TB] FAIL t1_cc_width: got %b want 0", cmd_complete_irq); end
    total++; if (starts !== 0) begin bad++; $display("[TB] FAIL t1_no_dat: got %0d want 0", starts); end
  endtask

  task automatic test_write_blocks();
    int dc = 0;
    start_cmd(1'b1, 1'b0, 16'd3);
    tick(); tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (dat_blk_start !== 1'b1 || seq_state !== 3'd2) begin bad++; $display("[TB] FAIL t2_first_start: got %b/%0d want 1/2", dat_blk_start, seq_state); end
    total++; if (blocks_left !== 16'd3) begin bad++; $display("[TB] FAIL t2_left_init: got %0d want 3", blocks_left); end
    for (int b = 0; b < 3; b++) begin
      tick();
      total++; if (dat_blk_start !== 1'b0) begin bad++; $display("[TB] FAIL t2_start_width: got %b want 0", dat_blk_start); end
      tick();
      dat_blk_done = 1'b1; tick(); dat_blk_done = 1'b0;
      total++; if (blocks_left !== 16'(2 - b)) begin bad++; $display("[TB] FAIL t2_left: got %0d want %0d", blocks_left, 2 - b); end
      dc += int'(dat_complete_irq);
      if (b < 2) begin
        total++; if (seq_state !== 3'd3) begin bad++; $display("[TB] FAIL t2_gap: got %0d want 3", seq_state); end
        tick();
        total++; if (dat_blk_start !== 1'b0) begin bad++; $display("[TB] FAIL t2_gap_early: got %b want 0", dat_blk_start); end
        tick();
        total++; if (dat_blk_start !== 1'b1) begin bad++; $display("[TB] FAIL t2_next_start: got %b want 1", dat_blk_start); end
      end
    end
    total++; if (seq_state !== 3'd0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL t2_end_idle: got %0d/%b want 0/0", seq_state, busy); end
    tick();
    dc += int'(dat_complete_irq);
    total++; if (dc !== 1) begin bad++; $display("[TB] FAIL t2_dc_count: got %0d want 1", dc); end
  endtask

  task automatic test_read_stop();
    start_cmd(1'b1, 1'b1, 16'd4);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    tick();
    dat_blk_done = 1'b1; tick(); dat_blk_done = 1'b0;
    tick(); tick();
    total++; if (dat_blk_start !== 1'b1) begin bad++; $display("[TB] FAIL t3_blk2_start: got %b want 1", dat_blk_start); end
    blk_gap_stop = 1'b1;
    tick();
    dat_blk_done = 1'b1; tick(); dat_blk_done = 1'b0;
    total++; if (seq_state !== 3'd4 || blk_gap_irq !== 1'b1) begin bad++; $display("[TB] FAIL t3_stop: got %0d/%b want 4/1", seq_state, blk_gap_irq); end
    total++; if (sd_clk_pause !== 1'b1 || blocks_left !== 16'd2) begin bad++; $display("[TB] FAIL t3_pause_left: got %b/%0d want 1/2", sd_clk_pause, blocks_left); end
    tick();
    total++; if (blk_gap_irq !== 1'b0) begin bad++; $display("[TB] FAIL t3_bg_width: got %b want 0", blk_gap_irq); end
    continue_req = 1'b1; tick(); continue_req = 1'b0;
    total++; if (seq_state !== 3'd4 || sd_clk_pause !== 1'b1) begin bad++; $display("[TB] FAIL t3_cont_blocked: got %0d/%b want 4/1", seq_state, sd_clk_pause); end
    blk_gap_stop = 1'b0;
    continue_req = 1'b1; tick(); continue_req = 1'b0;
    total++; if (seq_state !== 3'd3 || sd_clk_pause !== 1'b0) begin bad++; $display("[TB] FAIL t3_resume: got %0d/%b want 3/0", seq_state, sd_clk_pause); end
    tick(); tick();
    total++; if (dat_blk_start !== 1'b1) begin bad++; $display("[TB] FAIL t3_blk3_start: got %b want 1", dat_blk_start); end
    dat_blk_done = 1'b1; tick(); dat_blk_done = 1'b0;
    tick(); tick();
    dat_blk_done = 1'b1; tick(); dat_blk_done = 1'b0;
    total++; if (dat_complete_irq !== 1'b1 || blocks_left !== 16'd0 || seq_state !== 3'd0) begin bad++; $display("[TB] FAIL t3_done: got %b/%0d/%0d want 1/0/0", dat_complete_irq, blocks_left, seq_state); end
  endtask

  task automatic test_gap_abort();
    start_cmd(1'b1, 1'b0, 16'd2);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    dat_blk_done = 1'b1; tick(); dat_blk_done = 1'b0;
    blk_gap_stop = 1'b1;
    tick();
    total++; if (seq_state !== 3'd4 || blk_gap_irq !== 1'b1 || sd_clk_pause !== 1'b0) begin bad++; $display("[TB] FAIL t_gap_stop: got %0d/%b/%b want 4/1/0", seq_state, blk_gap_irq, sd_clk_pause); end
    tick();
    abort_req = 1'b1; tick(); abort_req = 1'b0; blk_gap_stop = 1'b0;
    total++; if (dat_complete_irq !== 1'b1 || seq_state !== 3'd0) begin bad++; $display("[TB] FAIL t_abort: got %b/%0d want 1/0", dat_complete_irq, seq_state); end
    total++; if (blocks_left !== 16'd1 || xfer_err !== 1'b0) begin bad++; $display("[TB] FAIL t_abort_left: got %0d/%b want 1/0", blocks_left, xfer_err); end
  endtask

  task automatic test_cmd_err();
    start_cmd(1'b1, 1'b0, 16'd2);
    tick();
    cmd_done = 1'b1; cmd_err = 1'b1; tick(); cmd_done = 1'b0; cmd_err = 1'b0;
    total++; if (xfer_err !== 1'b1 || cmd_complete_irq !== 1'b1) begin bad++; $display("[TB] FAIL t4_err: got %b/%b want 1/1", xfer_err, cmd_complete_irq); end
    total++; if (dat_blk_start !== 1'b0 || seq_state !== 3'd0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL t4_idle: got %b/%0d/%b want 0/0/0", dat_blk_start, seq_state, busy); end
  endtask

  task automatic test_dat_err();
    start_cmd(1'b1, 1'b0, 16'd8);
    total++; if (xfer_err !== 1'b0) begin bad++; $display("[TB] FAIL t5_clear_prev: got %b want 0", xfer_err); end
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    tick();
    dat_blk_err = 1'b1; tick(); dat_blk_err = 1'b0;
    total++; if (dat_complete_irq !== 1'b1 || xfer_err !== 1'b1) begin bad++; $display("[TB] FAIL t5_err: got %b/%b want 1/1", dat_complete_irq, xfer_err); end
    total++; if (blocks_left !== 16'd8 || seq_state !== 3'd0) begin bad++; $display("[TB] FAIL t5_left: got %0d/%0d want 8/0", blocks_left, seq_state); end
    start_cmd(1'b0, 1'b0, 16'd0);
    total++; if (xfer_err !== 1'b0) begin bad++; $display("[TB] FAIL t5_clear: got %b want 0", xfer_err); end
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    tick();
  endtask

  task automatic test_resets();
    start_cmd(1'b1, 1'b1, 16'd4);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    blk_gap_stop = 1'b1;
    dat_blk_done = 1'b1; tick(); dat_blk_done = 1'b0;
    total++; if (sd_clk_pause !== 1'b1) begin bad++; $display("[TB] FAIL t6_pre_pause: got %b want 1", sd_clk_pause); end
    sw_rst = 1'b1; tick(); sw_rst = 1'b0; blk_gap_stop = 1'b0;
    total++; if (all_out !== 27'd0) begin bad++; $display("[TB] FAIL t6_sw_rst: got %h want 0", all_out); end
    start_cmd(1'b1, 1'b0, 16'd5);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    start_cmd(1'b1, 1'b0, 16'd9);
    total++; if (blocks_left !== 16'd5 || cmd_issue !== 1'b0 || seq_state !== 3'd2) begin bad++; $display("[TB] FAIL t6_busy_start: got %0d/%b/%0d want 5/0/2", blocks_left, cmd_issue, seq_state); end
    #2 rstn = 1'b0;
    #1;
    total++; if (all_out !== 27'd0) begin bad++; $display("[TB] FAIL t6_async_rst: got %h want 0", all_out); end
    tick();
    rstn = 1'b1;
    tick();
    total++; if (all_out !== 27'd0) begin bad++; $display("[TB] FAIL t6_after_rst: got %h want 0", all_out); end
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0; sw_rst = 1'b0; cmd_start = 1'b0; dat_present = 1'b0; dat_trans_dir = 1'b0;
    block_count = 16'd0; blk_gap_stop = 1'b0; continue_req = 1'b0; abort_req = 1'b0;
    cmd_done = 1'b0; cmd_err = 1'b0; dat_blk_done = 1'b0; dat_blk_err = 1'b0;
    test_reset();
    test_cmd_only();
    test_write_blocks();
    test_read_stop();
    test_gap_abort();
    test_cmd_err();
    test_dat_err();
    test_resets();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
